rgb_pwm_multi: RTL
==================

Name: rgb_pwm_multi

Overview:
- Parametrised N-channel PWM generator; successor to the single-channel RGB PWM.
- All channels share one period counter, so R/G/B (or more channels) stay phase-aligned.
- Adds double-buffered period and duty registers, so updates take effect only at a period boundary and never cause glitches.
- Adds per-channel enable, full-on handling and a period-start strobe for the upstream colour sequencer.

Parameters:
- WIDTH, 16, bit width of the period and duty values.
- CHANNELS, 3, number of PWM outputs.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- countmax  in  WIDTH  requested period in clk cycles; 0 means stopped.
- hivalue  in  CHANNELS*WIDTH  requested high time per channel; channel i occupies bits [i*WIDTH +: WIDTH].
- chan_en  in  CHANNELS  requested per-channel enable.
- load  in  1  one-cycle strobe; captures countmax, hivalue and chan_en into the pending registers.
- outpulse  out  CHANNELS  PWM outputs (registered).
- nopulse  out  CHANNELS  high when the channel produces no pulse in the active period (registered).
- period_start  out  1  one-cycle pulse on the first cycle of each active period.
- pending  out  1  a loaded update is waiting for the next boundary.

Behaviour:
- Reset (synchronous, active-high) sets the following, all cleared in the same cycle:
  - active and pending registers to 0;
  - cnt to 0;
  - outpulse to 0, nopulse to all-ones, period_start to 0, pending to 0.
- Register sets:
  - pending: p_max, p_hi[i], p_en.
  - active: a_max, a_hi[i], a_en.
- Load:
  - When load=1, pending registers take the input values and the pending flag is set.
  - A later load before the boundary overwrites the earlier one; only the last load is applied.
- Boundary:
  - A boundary occurs when (a_max!=0 and cnt==a_max-1), or when a_max==0 (every cycle while stopped).
  - At a boundary with the pending flag set: active <= pending, pending flag cleared, cnt <= 0.
  - If load and boundary coincide, the boundary applies the previous pending contents (if any). The new load is then captured as pending, with the flag left set.
- Counter:
  - If a_max==0, cnt holds 0.
  - Otherwise cnt runs 0..a_max-1 and wraps to 0.
  - cnt is WIDTH bits. countmax=2^WIDTH-1 is legal and never overflows.
- Output timing:
  - Outputs are registered.
  - Let cnt_n and a_*_n denote the next-cycle values. Then outpulse[i] <= a_en_n[i] && a_max_n!=0 && (cnt_n < a_hi_n[i]).
  - This means outpulse is high for exactly a_hi[i] cycles starting on the period's first cycle, aligned with period_start. There is no extra latency relative to cnt.
  - The comparison is unsigned WIDTH-bit.
- Full-on: a_hi[i] >= a_max with a_max!=0 gives outpulse[i] constantly high and nopulse[i]=0.
- nopulse[i] <= !a_en_n[i] || a_max_n==0 || a_hi_n[i]==0.
- period_start <= (a_max_n!=0) && (cnt_n==0).
  - With a_max==1 it is high every cycle.
  - It fires on the first active cycle after leaving the stopped state.
- Start from stopped: a load with countmax!=0 while stopped gives the following sequence:
  - the pending flag is set at edge N;
  - the boundary applies at edge N+1;
  - the first period_start and outpulse appear at the outputs after edge N+1.
- Stop: a load with countmax=0 takes effect at the next boundary. After that, all outpulse are 0 and all nopulse are 1.
- Reset mid-period overrides everything, including a coincident load; the load is discarded.
- chan_en changes affect outputs only at a boundary, like duty values.

Test Plan:
- Reset state: hold reset 3 cycles with load=1 -> outpulse=000, nopulse=111, period_start=0, pending=0 throughout and after release.
- Basic PWM: load countmax=8, hi={0,3,6}, en=111 -> ch0 high 6 of every 8 cycles, ch1 high 3 of 8, ch2 never high with nopulse[2]=1. period_start every 8 cycles, coincident with both rising edges.
- Glitch-free update: mid-period (cnt=4) load hi ch0=3 -> current period keeps 6 high cycles, pending=1. The next period shows 3 high cycles and pending clears on the boundary.
- Load at boundary and overwrite:
  - A load on the cnt=7 cycle is not applied until the following boundary: exactly one more period uses the old values.
  - Two loads (hi=2, then hi=5) in the same period -> next period uses 5.
- Full-on/disable: hi ch0=9 with countmax=8 -> outpulse[0] constantly 1, nopulse[0]=0. en[1]=0 -> outpulse[1]=0, nopulse[1]=1 from the boundary onward.
- Edge periods: countmax=1 with hi=1 -> outpulse=1 and period_start=1 every cycle. Load countmax=0 -> all outputs off from the boundary. Reset asserted at cnt=3 -> outputs cleared on the next edge and the counter restarts stopped.

Source files
------------

// File: rtl/rgb_pwm_multi.sv
// ============================================================================
//  Module   : rgb_pwm_multi
//  Brief    : N-channel phase-aligned PWM with double-buffered period/duty/enable
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_pwm_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          countmax,
    input  logic [CHANNELS*WIDTH-1:0] hivalue,
    input  logic [CHANNELS-1:0]       chan_en,
    input  logic                      load,
    output logic [CHANNELS-1:0]       outpulse,
    output logic [CHANNELS-1:0]       nopulse,
    output logic                      period_start,
    output logic                      pending
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Pending (shadow) and active register sets
    logic [WIDTH-1:0]          r_p_max;
    logic [CHANNELS*WIDTH-1:0] r_p_hi;
    logic [CHANNELS-1:0]       r_p_en;
    logic                      r_pend;

    logic [WIDTH-1:0]          r_a_max;
    logic [CHANNELS*WIDTH-1:0] r_a_hi;
    logic [CHANNELS-1:0]       r_a_en;
    logic [WIDTH-1:0]          r_cnt;

    logic [CHANNELS-1:0]       r_outpulse;
    logic [CHANNELS-1:0]       r_nopulse;
    logic                      r_period_start;

    logic                      w_boundary;
    logic                      w_apply;
    logic                      w_run_n;
    logic [WIDTH-1:0]          w_max_n;
    logic [CHANNELS*WIDTH-1:0] w_hi_n;
    logic [CHANNELS-1:0]       w_en_n;
    logic [WIDTH-1:0]          w_cnt_n;
    logic [CHANNELS-1:0]       w_out_n;
    logic [CHANNELS-1:0]       w_nop_n;

    // While stopped every cycle is a boundary, so a pending start applies one edge after load
    assign w_boundary = (r_a_max == '0) || (r_cnt == r_a_max - c_ONE);
    assign w_apply    = w_boundary && r_pend;

    assign w_max_n = w_apply ? r_p_max : r_a_max;
    assign w_hi_n  = w_apply ? r_p_hi  : r_a_hi;
    assign w_en_n  = w_apply ? r_p_en  : r_a_en;
    assign w_cnt_n = w_boundary ? '0 : r_cnt + c_ONE;
    assign w_run_n = (w_max_n != '0);

    // Outputs are computed from next-cycle state so they line up with cnt, no extra latency
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [WIDTH-1:0] w_hi_ch;
            assign w_hi_ch    = w_hi_n[i*WIDTH +: WIDTH];
            assign w_out_n[i] = w_en_n[i] && w_run_n && (w_cnt_n < w_hi_ch);
            assign w_nop_n[i] = !w_en_n[i] || !w_run_n || (w_hi_ch == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_max        <= '0;
            r_p_hi         <= '0;
            r_p_en         <= '0;
            r_pend         <= 1'b0;
            r_a_max        <= '0;
            r_a_hi         <= '0;
            r_a_en         <= '0;
            r_cnt          <= '0;
            r_outpulse     <= '0;
            r_nopulse      <= '1;
            r_period_start <= 1'b0;
        end else begin
            // A coincident load lands after the boundary has consumed the old pending set
            if (load) begin
                r_p_max <= countmax;
                r_p_hi  <= hivalue;
                r_p_en  <= chan_en;
                r_pend  <= 1'b1;
            end else if (w_apply) begin
                r_pend  <= 1'b0;
            end
            r_a_max        <= w_max_n;
            r_a_hi         <= w_hi_n;
            r_a_en         <= w_en_n;
            r_cnt          <= w_cnt_n;
            r_outpulse     <= w_out_n;
            r_nopulse      <= w_nop_n;
            r_period_start <= w_run_n && (w_cnt_n == '0);
        end
    end

    assign outpulse     = r_outpulse;
    assign nopulse      = r_nopulse;
    assign period_start = r_period_start;
    assign pending      = r_pend;

endmodule

`default_nettype wire
